// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph encodings {g,f,e,d,c,b,a}
// (active-high) and the special nibble codes understood by the decoder.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Nibble value rendered as a minus sign
    localparam logic [3:0] BCD_DASH = 4'hA;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display bus between BCD-producing logic (master) and the scan
// controller (slave): digit data and masks in, pin-level drive out.
interface seg7_scan_ctrl_if #(
    parameter int N_DIGITS = 8
);
    import seg7_pkg::*;

    logic [4*N_DIGITS-1:0] data_bcd;
    logic [N_DIGITS-1:0]   dp_mask;
    logic [N_DIGITS-1:0]   blank_mask;
    logic                  lz_suppress;
    logic                  blink_en;
    logic [N_DIGITS-1:0]   blink_mask;
    logic [N_DIGITS-1:0]   light_code;
    logic [SEG_W-1:0]      decode;
    logic                  dp_out;
    logic                  frame_done;

    modport master (
        output data_bcd, dp_mask, blank_mask, lz_suppress, blink_en, blink_mask,
        input  light_code, decode, dp_out, frame_done
    );

    modport slave (
        input  data_bcd, dp_mask, blank_mask, lz_suppress, blink_en, blink_mask,
        output light_code, decode, dp_out, frame_done
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to seven-segment lookup (active-high segments).
// 0-9 give the usual glyphs, 0xA a dash, 0xB-0xF are dark.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:     seg = SEG_0;
            4'd1:     seg = SEG_1;
            4'd2:     seg = SEG_2;
            4'd3:     seg = SEG_3;
            4'd4:     seg = SEG_4;
            4'd5:     seg = SEG_5;
            4'd6:     seg = SEG_6;
            4'd7:     seg = SEG_7;
            4'd8:     seg = SEG_8;
            4'd9:     seg = SEG_9;
            BCD_DASH: seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner. A prescaler defines
// digit slots; display data is latched once per frame so a frame never
// mixes old and new values. Output pins are registered and updated on the
// slot edge, so anode and segment changes happen together.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int SCAN_DIV       = 131233,
    parameter int BLINK_FRAMES   = 48,
    parameter bit AN_ACTIVE_LOW  = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [N_DIGITS-1:0] AN_INV  = {N_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]    SEG_INV = {SEG_W{SEG_ACTIVE_LOW}};

    logic [PRE_W-1:0] pre_cnt_reg;
    logic             running_reg, running_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [FR_W-1:0]  frame_cnt_reg, frame_cnt_next;
    logic             phase_reg, phase_next;
    logic             tick, frame_start;

    logic [4*N_DIGITS-1:0] data_reg;
    logic [N_DIGITS-1:0]   dp_mask_reg, blank_mask_reg, blink_mask_reg;
    logic                  lz_reg, blink_en_reg;

    // Values the next slot is rendered from: fresh inputs at a frame
    // start (the same ones being latched), otherwise the frame's shadow copy.
    logic [4*N_DIGITS-1:0] data_eff;
    logic [N_DIGITS-1:0]   dp_mask_eff, blank_mask_eff, blink_mask_eff;
    logic                  lz_eff, blink_en_eff;

    logic [3:0]          nibbles [N_DIGITS];
    logic [N_DIGITS-1:0] zero_from;
    logic [N_DIGITS-1:0] digit_dark;

    logic [3:0]          cur_nibble;
    logic [SEG_W-1:0]    cur_seg;
    logic                cur_dark;
    logic [N_DIGITS-1:0] cur_onehot;

    logic [N_DIGITS-1:0] light_code_reg;
    logic [SEG_W-1:0]    decode_reg;
    logic                dp_out_reg;
    logic                frame_done_reg;

    assign tick        = (pre_cnt_reg == PRE_W'(SCAN_DIV - 1));
    // The very first tick after reset also starts a frame, lighting digit 0
    assign frame_start = tick & (~running_reg | (idx_reg == IDX_W'(N_DIGITS - 1)));

    // Prescaler: free-running slot timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pre_cnt_reg <= '0;
        else if (tick)  pre_cnt_reg <= '0;
        else            pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
    end

    // Next scan index, frame counter and blink phase
    always_comb begin
        running_next   = running_reg;
        idx_next       = idx_reg;
        frame_cnt_next = frame_cnt_reg;
        phase_next     = phase_reg;
        if (tick) begin
            running_next = 1'b1;
            idx_next     = frame_start ? '0 : idx_reg + IDX_W'(1);
        end
        if (frame_start) begin
            if (frame_cnt_reg == FR_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_next = '0;
                phase_next     = ~phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + FR_W'(1);
            end
        end
    end

    // Scan state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_reg   <= 1'b0;
            idx_reg       <= '0;
            frame_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else begin
            running_reg   <= running_next;
            idx_reg       <= idx_next;
            frame_cnt_reg <= frame_cnt_next;
            phase_reg     <= phase_next;
        end
    end

    // Shadow latch of display inputs, once per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg       <= '0;
            dp_mask_reg    <= '0;
            blank_mask_reg <= '0;
            lz_reg         <= 1'b0;
            blink_en_reg   <= 1'b0;
            blink_mask_reg <= '0;
        end else if (frame_start) begin
            data_reg       <= bus.data_bcd;
            dp_mask_reg    <= bus.dp_mask;
            blank_mask_reg <= bus.blank_mask;
            lz_reg         <= bus.lz_suppress;
            blink_en_reg   <= bus.blink_en;
            blink_mask_reg <= bus.blink_mask;
        end
    end

    // Select live or shadowed display data for the slot being rendered
    always_comb begin
        data_eff       = frame_start ? bus.data_bcd    : data_reg;
        dp_mask_eff    = frame_start ? bus.dp_mask     : dp_mask_reg;
        blank_mask_eff = frame_start ? bus.blank_mask  : blank_mask_reg;
        lz_eff         = frame_start ? bus.lz_suppress : lz_reg;
        blink_en_eff   = frame_start ? bus.blink_en    : blink_en_reg;
        blink_mask_eff = frame_start ? bus.blink_mask  : blink_mask_reg;
    end

    // zero_from[i]: digit i and every higher digit hold zero
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run          = run & (data_eff[4*i +: 4] == 4'h0);
            zero_from[i] = run;
        end
    end

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign nibbles[gi]    = data_eff[4*gi +: 4];
            // Digit 0 is exempt from leading-zero suppression
            assign digit_dark[gi] = blank_mask_eff[gi]
                                  | (blink_en_eff & blink_mask_eff[gi] & phase_next)
                                  | (lz_eff & zero_from[gi] & (gi != 0));
        end
    endgenerate

    assign cur_nibble = nibbles[idx_next];
    assign cur_dark   = digit_dark[idx_next];
    assign cur_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_next;

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Pin registers: polarity applied only here, updated on slot ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_code_reg <= AN_INV;
            decode_reg     <= SEG_INV;
            dp_out_reg     <= SEG_ACTIVE_LOW;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= tick & (idx_next == IDX_W'(N_DIGITS - 1));
            if (tick) begin
                light_code_reg <= cur_onehot ^ AN_INV;
                decode_reg     <= (cur_dark ? SEG_BLANK : cur_seg) ^ SEG_INV;
                dp_out_reg     <= (dp_mask_eff[idx_next] & ~cur_dark) ^ SEG_ACTIVE_LOW;
            end
        end
    end

    assign bus.light_code = light_code_reg;
    assign bus.decode     = decode_reg;
    assign bus.dp_out     = dp_out_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a slot-level reference model pushes
// the expected pin state of every digit slot; a monitor pops one entry
// each time the anode pattern changes and checks the outputs stay steady
// in between. A second, inverted-polarity instance shares all stimulus.
module tb_seg7_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BF  = 2;

    typedef struct packed {
        logic [3:0] light;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.N_DIGITS(N)) bus_p ();
    seg7_scan_ctrl_if #(.N_DIGITS(N)) bus_n ();

    seg7_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(DIV), .BLINK_FRAMES(BF),
                     .AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0))
        dut_p (.clk(clk), .rst_n(rst_n), .bus(bus_p));

    seg7_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(DIV), .BLINK_FRAMES(BF),
                     .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1))
        dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    int   checks = 0;
    int   errors = 0;
    int   txns   = 0;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Compare both instances against one expected active-high pin state
    task automatic cmp_pins(input string tag, input exp_t e);
        logic [3:0] inv_l;
        logic [6:0] inv_s;
        logic       inv_d;
        inv_l = ~e.light;
        inv_s = ~e.seg;
        inv_d = ~e.dp;
        chk({tag, "_light"},   {28'b0, bus_p.light_code}, {28'b0, e.light});
        chk({tag, "_decode"},  {25'b0, bus_p.decode},     {25'b0, e.seg});
        chk({tag, "_dp"},      {31'b0, bus_p.dp_out},     {31'b0, e.dp});
        chk({tag, "_fd"},      {31'b0, bus_p.frame_done}, {31'b0, e.fd});
        chk({tag, "_n_light"}, {28'b0, bus_n.light_code}, {28'b0, inv_l});
        chk({tag, "_n_decode"},{25'b0, bus_n.decode},     {25'b0, inv_s});
        chk({tag, "_n_dp"},    {31'b0, bus_n.dp_out},     {31'b0, inv_d});
        chk({tag, "_n_fd"},    {31'b0, bus_n.frame_done}, {31'b0, e.fd});
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  4'hA: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // Reference model: slot number from elapsed cycles, frame data latched at digit 0
    initial begin
        int cyc, slot_n, s, k;
        logic [15:0] c_data, upper;
        logic [3:0]  c_dp, c_blank, c_bmask;
        logic        c_lz, c_ben, phase, dark;
        exp_t        e;
        cyc = 0;
        c_data = '0; c_dp = '0; c_blank = '0; c_bmask = '0; c_lz = 1'b0; c_ben = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0;
                q.delete();
            end else begin
                cyc++;
                if (cyc % DIV == 0) begin
                    slot_n = cyc / DIV - 1;
                    s      = slot_n % N;
                    k      = slot_n / N + 1;
                    if (s == 0) begin
                        c_data  = bus_p.data_bcd;
                        c_dp    = bus_p.dp_mask;
                        c_blank = bus_p.blank_mask;
                        c_lz    = bus_p.lz_suppress;
                        c_ben   = bus_p.blink_en;
                        c_bmask = bus_p.blink_mask;
                    end
                    phase   = ((k / BF) % 2) == 1;
                    upper   = c_data >> (4 * s);
                    dark    = c_blank[s] | (c_ben & c_bmask[s] & phase)
                            | (c_lz && s != 0 && upper == 16'h0);
                    e.light = 4'b0001 << s;
                    e.seg   = dark ? 7'h00 : glyph(c_data[4*s +: 4]);
                    e.dp    = c_dp[s] & ~dark;
                    e.fd    = (s == N - 1);
                    q.push_back(e);
                end
            end
        end
    end

    // Monitor: a new anode pattern is one transaction; outputs steady otherwise
    initial begin
        logic [3:0] prev_light;
        exp_t       last, e, idle;
        logic       have_last;
        prev_light = 4'b0;
        have_last  = 1'b0;
        idle       = '0;
        last       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_light = 4'b0;
                have_last  = 1'b0;
            end else if (bus_p.light_code != prev_light) begin
                if (q.size() == 0) begin
                    chk("unexpected_slot", {28'b0, bus_p.light_code}, 32'h0);
                end else begin
                    e = q.pop_front();
                    cmp_pins("slot", e);
                    txns++;
                    $display("txn %0d: light=%b decode=%h dp=%b frame_done=%b",
                             txns, bus_p.light_code, bus_p.decode, bus_p.dp_out, bus_p.frame_done);
                    last = e;
                    last.fd = 1'b0;
                    have_last = 1'b1;
                end
                prev_light = bus_p.light_code;
            end else begin
                cmp_pins(have_last ? "hold" : "idle", have_last ? last : idle);
            end
        end
    end

    task automatic drive(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                         input logic lz, input logic ben, input logic [3:0] bm);
        bus_p.data_bcd = d;  bus_n.data_bcd = d;
        bus_p.dp_mask = dp;  bus_n.dp_mask = dp;
        bus_p.blank_mask = bl; bus_n.blank_mask = bl;
        bus_p.lz_suppress = lz; bus_n.lz_suppress = lz;
        bus_p.blink_en = ben; bus_n.blink_en = ben;
        bus_p.blink_mask = bm; bus_n.blink_mask = bm;
    endtask

    // Apply a configuration at a random point within a frame and hold it
    task automatic apply_cfg(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                             input logic lz, input logic ben, input logic [3:0] bm,
                             input int frames);
        @(negedge clk);
        drive(d, dp, bl, lz, ben, bm);
        repeat (frames * N * DIV + $urandom_range(0, N * DIV - 1)) @(negedge clk);
    endtask

    task automatic check_inactive(input string tag);
        chk({tag, "_light"},    {28'b0, bus_p.light_code}, 32'h0);
        chk({tag, "_decode"},   {25'b0, bus_p.decode},     32'h0);
        chk({tag, "_dp"},       {31'b0, bus_p.dp_out},     32'h0);
        chk({tag, "_fd"},       {31'b0, bus_p.frame_done}, 32'h0);
        chk({tag, "_n_light"},  {28'b0, bus_n.light_code}, 32'hF);
        chk({tag, "_n_decode"}, {25'b0, bus_n.decode},     32'h7F);
        chk({tag, "_n_dp"},     {31'b0, bus_n.dp_out},     32'h1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_inactive("reset_hold");
        rst_n = 1'b1;

        apply_cfg(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 3);
        apply_cfg(16'h5678, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 3);
        apply_cfg(16'h0070, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 3);
        apply_cfg(16'h0000, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 3);
        apply_cfg(16'hA000, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 3);
        apply_cfg(16'h1234, 4'b0010, 4'h0, 1'b0, 1'b0, 4'h0, 3);
        apply_cfg(16'h8888, 4'h0, 4'h0, 1'b0, 1'b1, 4'b0001, 8);

        for (int i = 0; i < 20; i++) begin
            logic [15:0] d;
            logic [3:0]  bl;
            d  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
            bl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            apply_cfg(d, 4'($urandom), bl, 1'($urandom), 1'($urandom), 4'($urandom),
                      $urandom_range(1, 3));
        end

        // Asynchronous reset in the middle of a slot, no clock edge before the check
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_inactive("async_reset");
        repeat (2) @(negedge clk);
        check_inactive("reset_hold2");
        rst_n = 1'b1;
        apply_cfg(16'h0905, 4'b0101, 4'h0, 1'b1, 1'b0, 4'h0, 3);
        apply_cfg(16'h4321, 4'h0, 4'b0100, 1'b0, 1'b1, 4'b1010, 4);

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 32'h0);
        chk("enough_txns", {31'b0, (txns >= 150)}, 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
